// File: rtl/sequential_multiplier_if.sv
// sequential_multiplier_if: start/done handshake and operand/product bus for the multiplier
interface sequential_multiplier_if #(parameter int N = 32);
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic start;
    logic [2*N-1:0] product;
    logic done;
    logic busy;
    modport master(output multiplicand, multiplier, start, input product, done, busy);
    modport slave(input multiplicand, multiplier, start, output product, done, busy);
endinterface

// File: rtl/sequential_multiplier.sv
// sequential_multiplier: unsigned NxN shift-and-add multiplier, one partial-product bit per clock
module sequential_multiplier #(parameter int N = 32) (
    input logic clk,
    input logic rst,
    sequential_multiplier_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    state_t state, state_n;
    logic [N-1:0] mcand_reg, mplier_reg, acc_hi;
    logic [CW-1:0] count;
    logic [N:0] sum;
    logic [2*N-1:0] product;
    logic done, busy;
    assign bus.product = product;
    assign bus.done = done;
    assign bus.busy = busy;
    assign sum = {1'b0, acc_hi} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next state: accept in IDLE, leave CALC on the last iteration, FINISH always returns to IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? CALC : IDLE;
            CALC:    state_n = (count == CW'(1)) ? FINISH : CALC;
            default: state_n = IDLE;
        endcase
    end
    // datapath: load operands, shift-add with the carry kept in sum[N], publish the product
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg <= '0;
            mplier_reg <= '0;
            acc_hi <= '0;
            count <= '0;
            product <= '0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        mcand_reg <= bus.multiplicand;
                        mplier_reg <= bus.multiplier;
                        acc_hi <= '0;
                        count <= CW'(N);
                        busy <= 1'b1;
                    end
                end
                CALC: begin
                    acc_hi <= sum[N:1];
                    mplier_reg <= {sum[0], mplier_reg[N-1:1]};
                    count <= count - CW'(1);
                end
                default: begin
                    product <= {acc_hi, mplier_reg};
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sequential_multiplier.sv
// tb_sequential_multiplier: directed and back-to-back random checks against a cycle-count/arithmetic model
module tb_sequential_multiplier;
    localparam int N = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int passed = 0;
    int total = 0;
    int cyc = 0;
    bit b2b = 1'b0;
    sequential_multiplier_if #(.N(N)) bus();
    sequential_multiplier #(.N(N)) dut(.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [63:0] m_prod = '0;
    logic [N-1:0] m_a = '0, m_b = '0;
    bit m_busy = 1'b0, m_done = 1'b0;
    int m_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: an accepted operation completes N+1 edges later with A*B; nothing is accepted while busy
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_prod = 64'(m_a) * 64'(m_b);
                end
            end else if (bus.start) begin
                m_busy = 1'b1;
                m_left = N + 1;
                m_a = bus.multiplicand;
                m_b = bus.multiplier;
            end
        end
    end

    int last_done = 0;
    bit have_last = 1'b0;
    // Compare DUT outputs with the model every cycle; in back-to-back mode check done spacing
    always @(negedge clk) begin
        cyc++;
        check("product", bus.product, m_prod);
        check("done", 64'(bus.done), 64'(m_done));
        check("busy", 64'(bus.busy), 64'(m_busy));
        if (bus.done) begin
            if (b2b && have_last) check("done_spacing", 64'(cyc - last_done), 64'(N + 2));
            have_last = b2b;
            last_done = cyc;
        end
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [63:0] exp, input string name);
        int k;
        bus.multiplicand = a;
        bus.multiplier = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.multiplicand = ~a;
        bus.multiplier = ~b;
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({name, "_latency"}, 64'(k), 64'(N + 1));
        check({name, "_product"}, bus.product, exp);
        @(negedge clk);
        check({name, "_done_fall"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int k, dones, cnt;
        bus.start = 1'b1;
        bus.multiplicand = 32'd5;
        bus.multiplier = 32'd5;
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_done", 64'(bus.done), 64'd0);
            check("rst_product", bus.product, 64'd0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 64'(bus.busy), 64'd0);

        run_op(32'd7, 32'd6, 64'd42, "basic");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "max");
        run_op(32'd0, 32'hDEADBEEF, 64'd0, "zero");

        bus.multiplicand = 32'd3;
        bus.multiplier = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        k = 10;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("busyprot_latency", 64'(k), 64'(N + 1));
        check("busyprot_product", bus.product, 64'd15);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("busyprot_no_second_done", 64'(dones), 64'd0);

        bus.multiplicand = 32'h12345678;
        bus.multiplier = 32'h100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_product", bus.product, 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'd0);
        run_op(32'd3, 32'd5, 64'd15, "after_rst");

        b2b = 1'b1;
        bus.start = 1'b1;
        dones = 0;
        cnt = 0;
        while (dones < 1000 && cnt < 1000 * (N + 2) + 200) begin
            bus.multiplicand = $urandom;
            bus.multiplier = $urandom;
            @(negedge clk);
            cnt++;
            if (bus.done) dones++;
        end
        check("b2b_done_count", 64'(dones), 64'd1000);
        bus.start = 1'b0;
        b2b = 1'b0;
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sequential_multiplier.md
# sequential_multiplier

Unsigned N×N shift-and-add multiplier producing a 2N-bit product, one partial-product bit per clock. It is the multiply counterpart of the team's sequential divider and uses the same start/done handshake, so datapath control can drive either unit interchangeably. It is unpipelined: one operation in flight, about N+1 cycles per result.

## Interface

- N, default 32, operand width in bits (N ≥ 2); the product is 2N bits.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- multiplicand  input  N  unsigned operand A, sampled only on the accept edge.
- multiplier  input  N  unsigned operand B, sampled only on the accept edge.
- start  input  1  request; honoured only when busy=0.
- product  output  2N  A*B; registered; holds the last result until the next completion.
- done  output  1  one-cycle pulse; product is valid in the same cycle.
- busy  output  1  high from the accept edge through the completion edge.

## Operation

- Reset (rst=1 at a clock edge): product=0, done=0, busy=0, state=IDLE. All internal registers clear. Reset wins over every other condition.
- States: IDLE, CALC, FINISH.
- IDLE:
  - done<=0.
  - If start=1: mcand_reg<=multiplicand, mplier_reg<=multiplier, acc_hi<=0, count<=N, busy<=1, go to CALC.
  - Otherwise stay in IDLE.
- CALC, once per cycle while count>0:
  - sum[N:0] = {1'b0,acc_hi} + (mplier_reg[0] ? {1'b0,mcand_reg} : 0).
  - Shift the (2N+1)-bit value {sum, mplier_reg} right by one: acc_hi<=sum[N:1], mplier_reg<={sum[0], mplier_reg[N-1:1]}.
  - count<=count-1.
  - When count reaches 0 (after exactly N iterations), go to FINISH.
  - The carry bit sum[N] must never be dropped; the adder is N+1 bits wide.
- FINISH: product<={acc_hi, mplier_reg}, done<=1, busy<=0, go to IDLE.
- count width: $clog2(N+1) bits.
- No overflow is possible; the 2N-bit product is exact for all inputs.
- start while busy=1 is ignored. It is not queued and not flagged.
- Operand inputs may change freely after the accept edge without affecting the result.
- Zero operands are not short-circuited; latency is data-independent.

## Timing

- Let edge E0 be the edge at which start=1 is sampled in IDLE (the accept edge).
  - busy=1 after E0.
  - CALC iterations occur at edges E1..EN.
  - FINISH executes at E(N+1): after it, done=1, busy=0, and product is updated.
  - done falls at E(N+2).
- Latency from accept to done high is N+1 edges (33 for N=32). Throughput is one result per N+2 cycles.
- Back-to-back: start held high or reasserted while done=1 is accepted at E(N+2), because the state is already IDLE. done still drops at that edge.
- Reset mid-operation (CALC or FINISH): at the reset edge, product=0, done=0, busy=0, state=IDLE. No done pulse is produced for the aborted operation.
- start and rst both high: reset wins and nothing is accepted.
- product changes only at the FINISH edge or the reset edge.

## Test plan

- Reset: hold rst for 2 cycles with start=1 -> product=0, done=0, busy=0 throughout. No acceptance while rst=1.
- Basic: N=32, A=7, B=6, start pulse at E0 -> busy=1 from E0; done=1 exactly after E33 with product=42; done=0 after E34.
- Extremes: A=B=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (checks the carry path). A=0, B=0xDEADBEEF -> product=0 with full 33-cycle latency.
- Busy protection: accept A=3, B=5; pulse start with A=9, B=9 at E10 while also changing the operand inputs -> single done, product=15, no second done.
- Reset mid-op: accept A=0x12345678, B=0x100; assert rst at E12 -> product=0, busy=0, no done. Then accept A=3, B=5 -> product=15 after 33 edges.
- Back-to-back plus random: hold start=1 continuously over 1000 random operand pairs -> each done is spaced N+2 cycles apart and every product equals the reference model A*B.
